// File: rtl/neurospider_pkg.sv
// Shared definitions for the neuron MAC datapath: default widths, state
// encoding and accumulator saturation limits.
package neurospider_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } mac_state_t;

    // Clamp values for the default accumulator width.
    localparam logic [ACC_W_DEF-1:0] ACC_SAT_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_SAT_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/serial_mult.sv
// Unsigned shift-add multiplier core: one multiplier bit per clock, LSB first.
// A start loads both magnitudes and clears the product; o_done flags the edge
// that consumes the last multiplier bit.
module serial_mult #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_mcand,
    input  logic [DATA_W-1:0]     i_mplier,
    output logic [2*DATA_W-1:0]   o_product,
    output logic                  o_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [2*DATA_W-1:0] r_product;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_active;

    // The multiplicand is shifted left each step, so adding it is the same as
    // adding (multiplicand << cnt); the multiplier shifts right to expose the next bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
            r_cnt     <= '0;
            r_active  <= 1'b0;
        end else if (i_start) begin
            r_mcand   <= {{DATA_W{1'b0}}, i_mcand};
            r_mplier  <= i_mplier;
            r_product <= '0;
            r_cnt     <= '0;
            r_active  <= 1'b1;
        end else if (r_active) begin
            if (r_mplier[0]) begin
                r_product <= r_product + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (o_done) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_done    = r_active && (r_cnt == CNT_W'(DATA_W - 1));
    assign o_product = r_product;

endmodule

// File: rtl/neuron_mac_unit.sv
// Signed multiply-accumulate step for one neuron input, sequenced by the
// adder FSM: start_add launches one acc += in_val * weight, sin_add_fin
// reports completion. The accumulator saturates and keeps a sticky overflow flag.
//
// state | meaning
// IDLE  | waiting for start_add; operands captured on accept
// MUL   | serial magnitude multiply, one bit per cycle
// ACC   | signed product added into the accumulator with saturation
// DONE  | one-cycle completion strobe, then back to IDLE
module neuron_mac_unit
    import neurospider_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_add,
    input  logic              clear_acc,
    input  logic [DATA_W-1:0] in_val,
    input  logic [DATA_W-1:0] weight,
    output logic              sin_add_fin,
    output logic              busy,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_ovf
);

    localparam logic [ACC_W:0]   L_ONE     = (ACC_W+1)'(1);
    localparam logic [ACC_W-1:0] L_SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] L_SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    mac_state_t r_state;
    mac_state_t w_next;

    logic                r_neg;
    logic [ACC_W-1:0]    r_acc;
    logic                r_ovf;

    logic                w_accept;
    logic                w_mul_done;
    logic [DATA_W-1:0]   w_in_mag;
    logic [DATA_W-1:0]   w_wt_mag;
    logic [2*DATA_W-1:0] w_product;
    logic [ACC_W:0]      w_prod_ext;
    logic [ACC_W:0]      w_prod_signed;
    logic [ACC_W:0]      w_sum;
    logic                w_sum_ovf;
    logic [ACC_W-1:0]    w_sum_sat;

    assign w_accept = (r_state == ST_IDLE) && start_add;

    // The most negative operand maps to magnitude 2^(DATA_W-1), which still
    // fits in DATA_W unsigned bits.
    assign w_in_mag = in_val[DATA_W-1] ? (~in_val + 1'b1) : in_val;
    assign w_wt_mag = weight[DATA_W-1] ? (~weight + 1'b1) : weight;

    serial_mult #(
        .DATA_W (DATA_W)
    ) u_serial_mult (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_accept),
        .i_mcand   (w_in_mag),
        .i_mplier  (w_wt_mag),
        .o_product (w_product),
        .o_done    (w_mul_done)
    );

    // Sign is applied after widening so that the magnitude product never wraps;
    // one guard bit above ACC_W exposes overflow of the addition.
    assign w_prod_ext    = {{(ACC_W+1-2*DATA_W){1'b0}}, w_product};
    assign w_prod_signed = r_neg ? (~w_prod_ext + L_ONE) : w_prod_ext;
    assign w_sum         = {r_acc[ACC_W-1], r_acc} + w_prod_signed;
    assign w_sum_ovf     = w_sum[ACC_W] != w_sum[ACC_W-1];
    assign w_sum_sat     = !w_sum_ovf     ? w_sum[ACC_W-1:0] :
                           w_sum[ACC_W]   ? L_SAT_MIN : L_SAT_MAX;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; DONE always returns to IDLE so start_add held high is
    // only seen once the unit is idle again.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start_add)  w_next = ST_MUL;
            ST_MUL:  if (w_mul_done) w_next = ST_ACC;
            ST_ACC:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Result sign is captured with the operands, which may change after accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= in_val[DATA_W-1] ^ weight[DATA_W-1];
        end
    end

    // Accumulator with saturation; a clear beats a coincident accumulate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (clear_acc) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == ST_ACC) begin
            r_acc <= w_sum_sat;
            if (w_sum_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign sin_add_fin = (r_state == ST_DONE);
    assign busy        = (r_state == ST_MUL) || (r_state == ST_ACC);
    assign acc_out     = r_acc;
    assign acc_ovf     = r_ovf;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Directed bench for neuron_mac_unit with a timeline model of each operation.
module tb_neuron_mac_unit;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam longint LIM_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint LIM_MIN = -(longint'(1) <<< (ACC_W-1));

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_add = 1'b0;
    logic              clear_acc = 1'b0;
    logic [DATA_W-1:0] in_val = '0;
    logic [DATA_W-1:0] weight = '0;
    logic              sin_add_fin;
    logic              busy;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    neuron_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .start_add   (start_add),
        .clear_acc   (clear_acc),
        .in_val      (in_val),
        .weight      (weight),
        .sin_add_fin (sin_add_fin),
        .busy        (busy),
        .acc_out     (acc_out),
        .acc_ovf     (acc_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_t counts edges since the accepting edge (-1 when idle).
    // Edges 0..DATA_W are busy, edge DATA_W+1 adds the product, the
    // following cycle carries the strobe, then the unit is idle again.
    longint m_acc = 0;
    bit     m_ovf = 1'b0;
    int     m_t = -1;
    longint m_a = 0;
    longint m_b = 0;
    longint m_sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t   = -1;
            m_acc = 0;
            m_ovf = 1'b0;
        end else begin
            if (m_t == DATA_W) begin
                m_sum = m_acc + m_a * m_b;
                if (m_sum > LIM_MAX) begin
                    m_acc = LIM_MAX;
                    m_ovf = 1'b1;
                end else if (m_sum < LIM_MIN) begin
                    m_acc = LIM_MIN;
                    m_ovf = 1'b1;
                end else begin
                    m_acc = m_sum;
                end
            end
            if (clear_acc) begin
                m_acc = 0;
                m_ovf = 1'b0;
            end
            if (m_t == -1) begin
                if (start_add) begin
                    m_t = 0;
                    m_a = longint'($signed(in_val));
                    m_b = longint'($signed(weight));
                end
            end else if (m_t == DATA_W + 1) begin
                m_t = -1;
            end else begin
                m_t++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_strobe", longint'(sin_add_fin), longint'(m_t == DATA_W + 1));
            chk("model_busy", longint'(busy), longint'(m_t >= 0 && m_t <= DATA_W));
            chk("model_acc", longint'($signed(acc_out)), m_acc);
            chk("model_ovf", longint'(acc_ovf), longint'(m_ovf));
        end
    end

    task automatic run_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input int clr_at, input int restart_at,
                          output int lat, output int nstrb);
        @(negedge clk);
        in_val    = a;
        weight    = b;
        start_add = 1'b1;
        lat   = -1;
        nstrb = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (sin_add_fin) begin
                nstrb++;
                if (lat < 0) lat = k;
            end
            start_add = (k == restart_at);
            clear_acc = (k == clr_at);
            if (k == 1) begin
                in_val = 8'($urandom);
                weight = 8'($urandom);
            end
        end
        start_add = 1'b0;
        clear_acc = 1'b0;
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear_acc = 1'b1;
        @(negedge clk);
        clear_acc = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_acc"},  longint'(acc_out), 0);
        chk({tag, "_ovf"},  longint'(acc_ovf), 0);
        chk({tag, "_fin"},  longint'(sin_add_fin), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
    endtask

    int lat;
    int nstrb;
    int strobes_after;

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;

        // Basic MAC and latency.
        run_op(8'd3, 8'd5, 0, 0, lat, nstrb);
        chk("basic_latency", lat, 10);
        chk("basic_nstrobe", nstrb, 1);
        chk("basic_acc", longint'($signed(acc_out)), 15);
        run_op(8'hFC, 8'd6, 0, 0, lat, nstrb);
        chk("neg_acc", longint'($signed(acc_out)), -9);

        // Sign corners.
        clear_pulse();
        chk("clear_acc0", longint'($signed(acc_out)), 0);
        run_op(8'h80, 8'h80, 0, 0, lat, nstrb);
        chk("minmin_acc", longint'($signed(acc_out)), 16384);
        run_op(8'h80, 8'h7F, 0, 0, lat, nstrb);
        chk("minmax_acc", longint'($signed(acc_out)), 128);

        // Saturation.
        clear_pulse();
        for (int i = 0; i < 32; i++) begin
            run_op(8'h7F, 8'h7F, 0, 0, lat, nstrb);
        end
        chk("sat32_acc", longint'($signed(acc_out)), 516128);
        chk("sat32_ovf", longint'(acc_ovf), 0);
        run_op(8'h7F, 8'h7F, 0, 0, lat, nstrb);
        chk("sat33_acc", longint'($signed(acc_out)), 524287);
        chk("sat33_ovf", longint'(acc_ovf), 1);
        run_op(8'hFF, 8'd1, 0, 0, lat, nstrb);
        chk("satdec_acc", longint'($signed(acc_out)), 524286);
        chk("satdec_ovf", longint'(acc_ovf), 1);
        clear_pulse();
        chk("satclr_acc", longint'($signed(acc_out)), 0);
        chk("satclr_ovf", longint'(acc_ovf), 0);

        // Start while busy is ignored.
        run_op(8'd7, 8'hFD, 0, 3, lat, nstrb);
        chk("busy_nstrobe", nstrb, 1);
        chk("busy_latency", lat, 10);
        chk("busy_acc", longint'($signed(acc_out)), -21);

        // Clear on the accumulate edge wins, strobe still issued.
        run_op(8'd5, 8'd5, 9, 0, lat, nstrb);
        chk("clracc_nstrobe", nstrb, 1);
        chk("clracc_latency", lat, 10);
        chk("clracc_acc", longint'($signed(acc_out)), 0);

        // Reset in the middle of an operation.
        run_op(8'd10, 8'd10, 0, 0, lat, nstrb);
        chk("pre_rst_acc", longint'($signed(acc_out)), 100);
        @(negedge clk);
        in_val    = 8'd9;
        weight    = 8'd9;
        start_add = 1'b1;
        @(negedge clk);
        start_add = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        strobes_after = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sin_add_fin) strobes_after++;
        end
        chk("midrst_nostrobe", strobes_after, 0);
        run_op(8'd2, 8'd2, 0, 0, lat, nstrb);
        chk("postrst_acc", longint'($signed(acc_out)), 4);
        chk("postrst_latency", lat, 10);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neuron_mac_unit.md
Name: neuron_mac_unit

Overview:
- Single-operation datapath directly downstream of mod_AdderFSM.
- Each startAdd pulse makes it perform one signed multiply-accumulate: acc += in_val * weight. It then returns a one-cycle completion strobe that drives the FSM's sinAddFin input.
- The multiply is shift-add and multi-cycle, so that the FSM sequencing is meaningful.
- The accumulator holds the neuron's running weighted sum. It saturates on overflow and is cleared between neurons.

Parameters:
- DATA_W, 8, width of in_val and weight (signed two's complement).
- ACC_W, 20, accumulator width (signed); ACC_W >= 2*DATA_W is required.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start_add  in  1  driven by FSM startAdd; sampled only in IDLE.
- clear_acc  in  1  synchronous clear of acc_out and acc_ovf.
- in_val  in  DATA_W  signed input operand; captured on the accepted start.
- weight  in  DATA_W  signed weight operand; captured on the accepted start.
- sin_add_fin  out  1  one-cycle completion pulse, to FSM sinAddFin.
- busy  out  1  high in MUL and ACC.
- acc_out  out  ACC_W  signed accumulated sum, registered.
- acc_ovf  out  1  sticky saturation flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; acc_out=0, acc_ovf=0, sin_add_fin=0, busy=0.
  - Internal counter and product registers are cleared.
  - Reset mid-operation abandons the operation; no strobe is issued afterwards.
- States:
  - IDLE -> MUL when start_add=1. At that edge: capture |in_val| and |weight| as DATA_W-bit unsigned magnitudes (-2^(DATA_W-1) magnitude fits), capture neg = sign(in_val) XOR sign(weight), zero the product, and set cnt=0.
  - MUL: each edge processes one multiplier bit, LSB first: if bit set, product += multiplicand << cnt; then cnt++. After DATA_W edges -> ACC.
  - ACC: one edge. Apply the sign to the 2*DATA_W-bit product, sign-extend it to ACC_W+1 bits, add it to acc_out, saturate, -> DONE.
  - DONE: sin_add_fin=1 (Moore output) for exactly one cycle, then -> IDLE unconditionally.
- Latency: with the accepting edge as edge 0, the updated acc_out is visible after edge DATA_W+1, and sin_add_fin is high in the following cycle.
  - Total: start to strobe = DATA_W+2 cycles (10 for DATA_W=8).
  - Back-to-back throughput: one operation per DATA_W+3 cycles.
- start_add outside IDLE is ignored; there is no queuing. start_add held high in DONE is not seen until IDLE.
- A zero operand still takes the full latency (fixed-latency contract).
- Saturation:
  - If the sum exceeds 2^(ACC_W-1)-1, clamp to that value; if it is below -2^(ACC_W-1), clamp to -2^(ACC_W-1).
  - Either clamp sets acc_ovf, which stays set until clear_acc or reset.
- clear_acc:
  - Zeroes acc_out and acc_ovf at the next edge, in any state.
  - If it coincides with the ACC edge, the clear wins and the product is discarded; the strobe is still issued.
  - In IDLE together with start_add, the clear is applied and the new operation starts; its product lands on 0.
- Operand inputs may change freely after the accepting edge.

Decomposition:
- Shared package neurospider_pkg holds:
  - state encoding constants (IDLE, MUL, ACC, DONE);
  - default DATA_W/ACC_W;
  - the saturation limit constants derived from ACC_W.
- One natural sub-module: serial_mult (magnitude shift-add core with start/done). neuron_mac_unit owns sign handling, accumulation, saturation and the strobe.

Test Plan:
- Reset then idle: rst low mid-sim -> acc_out=0, acc_ovf=0, sin_add_fin=0, busy=0 immediately, without waiting for a clk edge.
- Basic MAC: in_val=3, weight=5, pulse start_add -> sin_add_fin high exactly 10 cycles later for 1 cycle, acc_out=15. Then in_val=-4, weight=6 -> acc_out=-9.
- Sign corners: clear_acc; in_val=-128, weight=-128 -> acc_out=16384. Then in_val=-128, weight=127 -> acc_out=128.
- Saturation: clear, then 32 ops of 127*127 -> acc_out=516128, acc_ovf=0. 33rd op -> acc_out=524287, acc_ovf=1. One op of -1*1 -> acc_out=524286, acc_ovf stays 1. clear_acc -> both 0.
- Start while busy: pulse start_add again 3 cycles after accept -> ignored, exactly one strobe, acc reflects one product only. clear_acc on the ACC edge -> acc_out=0, strobe still issued.
- Reset mid-operation: assert rst low 5 cycles into MUL -> no sin_add_fin ever. A later start with 2*2 -> acc_out=4.
